csum_check: RTL and testbench

- Streaming verifier for the 16-bit ones-complement Internet checksum (IPv4/UDP/TCP) on the receive path.
- Accepts packet bytes as a valid/ready beat stream and accumulates 16-bit big-endian words with end-around carry.
- Reports one result per packet: the folded sum, and pass/fail where pass means the folded sum equals 16'hFFFF.
- Sits between the MAC/parser RX stream and the header-accept logic; the TX-side checksum generator produces the values this block verifies.

---
 rtl/csum_pkg.sv | 18 +
 rtl/csum_beat_sum.sv | 31 +++
 rtl/csum_check.sv | 110 +++++++++++
 tb/tb_csum_check.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/csum_pkg.sv
// rtl/csum_pkg.sv - shared types, constants and fold helper for the ones-complement checksum blocks
package csum_pkg;

  localparam int          CSUM_W    = 16;
  localparam logic [15:0] CSUM_GOOD = 16'hFFFF;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FOLD1 = 2'd1,
    FOLD2 = 2'd2,
    DONE  = 2'd3
  } csum_state_t;

  function automatic logic [16:0] csum_fold32(input logic [31:0] v);
    return {1'b0, v[15:0]} + {1'b0, v[31:16]};
  endfunction

endpackage

// File: rtl/csum_beat_sum.sv
// rtl/csum_beat_sum.sv - keep-masked sum of the 16-bit big-endian words of one stream beat
module csum_beat_sum #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int SUM_W  = 16 + $clog2(DATA_W / 16)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [KEEP_W-1:0] keep,
  output logic [SUM_W-1:0]  sum
);

  localparam int N_WORDS = DATA_W / 16;

  logic [DATA_W-1:0] masked;

  // keep[i] qualifies data[8*i +: 8], so the top byte (network byte 0) pairs with the top keep bit
  always_comb begin
    masked = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      masked[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    sum = '0;
    for (int w = 0; w < N_WORDS; w++) begin
      sum = sum + SUM_W'(masked[16*w +: 16]);
    end
  end

endmodule

// File: rtl/csum_check.sv
// rtl/csum_check.sv - streaming RX verifier for the 16-bit ones-complement Internet checksum
// Optional macro CSUM_CHECK_SEED_EN adds s_seed, a per-packet partial sum added on the first beat.
module csum_check
  import csum_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEEP_W-1:0] s_keep,
  input  logic              s_valid,
  input  logic              s_last,
`ifdef CSUM_CHECK_SEED_EN
  input  logic [15:0]       s_seed,
`endif
  output logic              s_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CSUM_W-1:0] res_sum,
  output logic              res_ok
);

  localparam int SUM_W = 16 + $clog2(DATA_W / 16);

  csum_state_t       state, state_d;
  logic [31:0]       acc;
  logic [SUM_W-1:0]  beat_sum;
  logic [15:0]       seed;
  logic [15:0]       fold_final;
  logic              ready_q;
  logic              accept;

  csum_beat_sum #(
    .DATA_W(DATA_W),
    .KEEP_W(KEEP_W),
    .SUM_W (SUM_W)
  ) u_beat_sum (
    .data(s_data),
    .keep(s_keep),
    .sum (beat_sum)
  );

`ifdef CSUM_CHECK_SEED_EN
  logic first_beat;

  // the beat after a last beat opens the next packet
  always_ff @(posedge clk) begin
    if (!rst_n) first_beat <= 1'b1;
    else if (accept) first_beat <= s_last;
  end

  assign seed = first_beat ? s_seed : 16'h0000;
`else
  assign seed = 16'h0000;
`endif

  assign s_ready    = ready_q;
  assign accept     = s_valid && ready_q;
  assign res_valid  = (state == DONE);
  assign fold_final = acc[15:0] + {15'b0, acc[16]};

  always_comb begin
    state_d = state;
    unique case (state)
      ACCUM:   if (accept && s_last) state_d = FOLD1;
      FOLD1:   state_d = FOLD2;
      FOLD2:   state_d = DONE;
      DONE:    if (res_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // s_ready is registered so it stays low while rst_n is held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ACCUM;
      ready_q <= 1'b0;
    end else begin
      state   <= state_d;
      ready_q <= (state_d == ACCUM);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      res_sum <= '0;
      res_ok  <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          // folding the previous value each beat keeps acc bounded for any length
          if (accept) acc <= 32'(acc[15:0]) + 32'(acc[31:16]) + 32'(beat_sum) + 32'(seed);
        end
        FOLD1: acc <= 32'(csum_fold32(acc));
        FOLD2: begin
          res_sum <= fold_final;
          res_ok  <= (fold_final == CSUM_GOOD);
        end
        DONE: begin
          if (res_ready) acc <= '0;
        end
        default: acc <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_csum_check.sv
// tb/tb_csum_check.sv - table-driven self-checking bench for csum_check
module tb_csum_check;

  localparam int DATA_W = 64;
  localparam int KEEP_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] s_data;
  logic [KEEP_W-1:0] s_keep;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_sum;
  logic              res_ok;
`ifdef CSUM_CHECK_SEED_EN
  logic [15:0]       s_seed = 16'h0000;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csum_check #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_keep   (s_keep),
    .s_valid  (s_valid),
    .s_last   (s_last),
`ifdef CSUM_CHECK_SEED_EN
    .s_seed   (s_seed),
`endif
    .s_ready  (s_ready),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_ok   (res_ok)
  );

  typedef struct {
    int                   n;
    logic [3:0][63:0]     data;
    logic [3:0][7:0]      keep;
    logic [15:0]          exp_sum;
    logic                 exp_ok;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!s_ready && k < 20) begin
      tick();
      k++;
    end
    if (!s_ready) check({name, "_ready_timeout"}, 32'(s_ready), 32'd1);
  endtask

  // sends the first cnt beats of v; s_last only on the packet's true final beat
  task automatic send_pkt(input vec_t v, input int cnt, input string name);
    for (int b = 0; b < cnt; b++) begin
      s_valid = 1'b1;
      s_data  = v.data[b];
      s_keep  = v.keep[b];
      s_last  = (b == v.n - 1);
      wait_ready(name);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    s_keep  = '0;
  endtask

  // counts edges from the cycle after the last-beat acceptance until res_valid
  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    string nm;
    nm = $sformatf("vec%0d", idx);
    send_pkt(v, v.n, nm);
    wait_result(lat);
    check({nm, "_latency"}, 32'(lat), 32'd2);
    check({nm, "_sum"}, 32'(res_sum), 32'(v.exp_sum));
    check({nm, "_ok"}, 32'(res_ok), 32'(v.exp_ok));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({nm, "_valid_drop"}, 32'(res_valid), 32'd0);
    check({nm, "_ready_back"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0; res_ready = 1'b0;

    // IPv4 header, correct checksum; tail of last beat is garbage under keep F0
    vecs[0].n = 3;
    vecs[0].data[0] = 64'h4500_0073_0000_4000; vecs[0].keep[0] = 8'hFF;
    vecs[0].data[1] = 64'h4011_b861_c0a8_0001; vecs[0].keep[1] = 8'hFF;
    vecs[0].data[2] = 64'hc0a8_00c7_dead_beef; vecs[0].keep[2] = 8'hF0;
    vecs[0].data[3] = '0;                      vecs[0].keep[3] = 8'h00;
    vecs[0].exp_sum = 16'hFFFF; vecs[0].exp_ok = 1'b1;
    // checksum off by one: FFFF + 1 wraps end-around to 0001
    vecs[1] = vecs[0];
    vecs[1].data[1] = 64'h4011_b862_c0a8_0001;
    vecs[1].exp_sum = 16'h0001; vecs[1].exp_ok = 1'b0;
    // odd length: 01 02 03 then padded
    vecs[2].n = 1;
    vecs[2].data = '0; vecs[2].keep = '0;
    vecs[2].data[0] = 64'h0102_03AA_BBCC_DDEE; vecs[2].keep[0] = 8'hE0;
    vecs[2].exp_sum = 16'h0402; vecs[2].exp_ok = 1'b0;
    // sixteen FFFF words
    vecs[3].n = 4;
    for (int b = 0; b < 4; b++) begin
      vecs[3].data[b] = '1;
      vecs[3].keep[b] = 8'hFF;
    end
    vecs[3].exp_sum = 16'hFFFF; vecs[3].exp_ok = 1'b1;
    // FFFF + 0001 carries out and wraps to 0001
    vecs[4].n = 1;
    vecs[4].data = '0; vecs[4].keep = '0;
    vecs[4].data[0] = 64'hFFFF_0001_0000_0000; vecs[4].keep[0] = 8'hFF;
    vecs[4].exp_sum = 16'h0001; vecs[4].exp_ok = 1'b0;
    // keep=0 terminating beat contributes nothing
    vecs[5].n = 1;
    vecs[5].data = '0; vecs[5].keep = '0;
    vecs[5].data[0] = 64'hFFFF_FFFF_FFFF_FFFF; vecs[5].keep[0] = 8'h00;
    vecs[5].exp_sum = 16'h0000; vecs[5].exp_ok = 1'b0;
    // masking on a non-last beat: 9ABC + DEF0 + 0011 = 179BD -> 79BE
    vecs[6].n = 2;
    vecs[6].data = '0; vecs[6].keep = '0;
    vecs[6].data[0] = 64'h1234_5678_9ABC_DEF0; vecs[6].keep[0] = 8'h0F;
    vecs[6].data[1] = 64'h0000_0000_0000_0011; vecs[6].keep[1] = 8'hFF;
    vecs[6].exp_sum = 16'h79BE; vecs[6].exp_ok = 1'b0;

    repeat (3) tick();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_sum", 32'(res_sum), 32'd0);
    check("rst_res_ok", 32'(res_ok), 32'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", 32'(s_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // result held under backpressure, then back-to-back packet
    send_pkt(vecs[0], vecs[0].n, "bp");
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_ready_c%0d", c), 32'(s_ready), 32'd0);
      check($sformatf("bp_valid_c%0d", c), 32'(res_valid), 32'd1);
      check($sformatf("bp_sum_c%0d", c), 32'(res_sum), 32'h0000FFFF);
      tick();
    end
    s_valid = 1'b1; s_data = vecs[2].data[0]; s_keep = vecs[2].keep[0]; s_last = 1'b1;
    res_ready = 1'b1;
    check("bp_no_accept_in_done", 32'(s_ready), 32'd0);
    tick();
    res_ready = 1'b0;
    check("bp_ready_next_cycle", 32'(s_ready), 32'd1);
    check("bp_valid_drop", 32'(res_valid), 32'd0);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    check("bp_next_accepted", 32'(s_ready), 32'd0);
    wait_result(lat);
    check("bp_next_latency", 32'(lat), 32'd2);
    check("bp_next_sum", 32'(res_sum), 32'h00000402);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // reset after two of three beats; no residue may reach the next packet
    send_pkt(vecs[0], 2, "mid");
    rst_n = 1'b0;
    tick();
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_res_sum", 32'(res_sum), 32'd0);
    check("mid_rst_res_ok", 32'(res_ok), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_ready_after_reset", 32'(s_ready), 32'd1);
    run_vec(vecs[4], 40);
    run_vec(vecs[3], 41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
